// File: rtl/pong_match_sequencer.sv
// Match-level sequencer above the ball/paddle engine: serve/play/pause/miss flow,
// score, lives and difficulty level, and the per-level serve speed.
module pong_match_sequencer #(
    parameter int LIVES          = 3,
    parameter int SERVE_DELAY    = 60,
    parameter int MISS_DELAY     = 90,
    parameter int HITS_PER_LEVEL = 8,
    parameter int SCORE_W        = 10
) (
    input  logic               clk_frame_i,
    input  logic               rst_i,
    input  logic               start_btn_i,
    input  logic               pause_btn_i,
    input  logic               hit_i,
    input  logic               miss_i,
    output logic               play_start_o,
    output logic               play_hold_o,
    output logic               freeze_o,
    output logic [3:0]         start_speed_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [2:0]         lives_o,
    output logic [1:0]         level_o,
    output logic [2:0]         state_o,
    output logic               game_over_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_MISS      = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam int MAX_DELAY = (SERVE_DELAY > MISS_DELAY) ? SERVE_DELAY : MISS_DELAY;
    localparam int CNT_W     = $clog2(MAX_DELAY);
    localparam int HIT_W     = $clog2(HITS_PER_LEVEL + 1);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_DELAY - 1);
    localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HITS_PER_LEVEL - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic               r_pause_q;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [HIT_W-1:0]   r_hit_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [2:0]         r_lives;
    logic [1:0]         r_level;
    logic               r_play_start;
    logic               r_hold;
    logic               r_freeze;
    logic               r_game_over;
    logic [3:0]         r_speed;
    logic               w_start_edge;
    logic               w_pause_edge;
    logic               w_play_start;
    logic               w_hold;
    logic               w_freeze;
    logic               w_game_over;

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [1:0] sat_inc_level(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    function automatic logic [3:0] speed_of(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 4'b0101;
            2'd1:    return 4'b1001;
            2'd2:    return 4'b1010;
            default: return 4'b1110;
        endcase
    endfunction

    // Button copies reset high so a button held through reset never produces an edge.
    always_ff @(posedge clk_frame_i) begin
        if (rst_i) begin
            r_start_q <= 1'b1;
            r_pause_q <= 1'b1;
        end else begin
            r_start_q <= start_btn_i;
            r_pause_q <= pause_btn_i;
        end
    end

    assign w_start_edge = start_btn_i & ~r_start_q;
    assign w_pause_edge = pause_btn_i & ~r_pause_q;

    always_ff @(posedge clk_frame_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER: if (w_start_edge) w_state_nxt = S_SERVE;
            S_SERVE:             if (r_frame_cnt == SERVE_LAST) w_state_nxt = S_PLAY;
            S_PLAY: begin
                // A miss takes precedence over both a hit and a pause edge.
                if (miss_i)            w_state_nxt = (r_lives > 3'd1) ? S_MISS : S_GAME_OVER;
                else if (w_pause_edge) w_state_nxt = S_PAUSE;
            end
            S_PAUSE:             if (w_pause_edge) w_state_nxt = S_PLAY;
            S_MISS:              if (r_frame_cnt == MISS_LAST) w_state_nxt = S_SERVE;
            default:             w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered copies line up with state_o.
    always_comb begin
        w_play_start = (r_state == S_SERVE) && (w_state_nxt == S_PLAY);
        w_hold       = !((w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE));
        w_freeze     = (w_state_nxt == S_PAUSE);
        w_game_over  = (w_state_nxt == S_GAME_OVER);
    end

    always_ff @(posedge clk_frame_i) begin
        if (rst_i) begin
            r_play_start <= 1'b0;
            r_hold       <= 1'b1;
            r_freeze     <= 1'b0;
            r_game_over  <= 1'b0;
            r_speed      <= 4'b0101;
        end else begin
            r_play_start <= w_play_start;
            r_hold       <= w_hold;
            r_freeze     <= w_freeze;
            r_game_over  <= w_game_over;
            r_speed      <= speed_of(r_level);
        end
    end

    always_ff @(posedge clk_frame_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
            r_hit_cnt   <= '0;
            r_score     <= '0;
            r_lives     <= 3'(LIVES);
            r_level     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_GAME_OVER: begin
                    if (w_start_edge) begin
                        r_frame_cnt <= '0;
                        r_hit_cnt   <= '0;
                        r_score     <= '0;
                        r_lives     <= 3'(LIVES);
                        r_level     <= 2'd0;
                    end
                end
                S_SERVE: r_frame_cnt <= (r_frame_cnt == SERVE_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
                S_MISS:  r_frame_cnt <= (r_frame_cnt == MISS_LAST) ? '0 : r_frame_cnt + CNT_W'(1);
                S_PLAY: begin
                    if (miss_i) begin
                        if (r_lives > 3'd1) begin
                            r_lives     <= r_lives - 3'd1;
                            r_frame_cnt <= '0;
                        end else begin
                            r_lives <= 3'd0;
                        end
                    end else if (hit_i) begin
                        r_score <= sat_inc_score(r_score);
                        if (r_hit_cnt == HIT_LAST) begin
                            r_hit_cnt <= '0;
                            r_level   <= sat_inc_level(r_level);
                        end else begin
                            r_hit_cnt <= r_hit_cnt + HIT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign play_start_o  = r_play_start;
    assign play_hold_o   = r_hold;
    assign freeze_o      = r_freeze;
    assign start_speed_o = r_speed;
    assign score_o       = r_score;
    assign lives_o       = r_lives;
    assign level_o       = r_level;
    assign state_o       = r_state;
    assign game_over_o   = r_game_over;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer: expected output snapshots are queued
// before each stimulus step and popped and compared once the step has been clocked.
module tb_pong_match_sequencer;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_MISS  = 3'd4;
    localparam logic [2:0] ST_GO    = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       pause_btn;
    logic       hit;
    logic       miss;
    logic       play_start;
    logic       play_hold;
    logic       freeze;
    logic [3:0] start_speed;
    logic [9:0] score;
    logic [2:0] lives;
    logic [1:0] level;
    logic [2:0] state;
    logic       game_over;

    pong_match_sequencer #(
        .LIVES(3), .SERVE_DELAY(60), .MISS_DELAY(90), .HITS_PER_LEVEL(8), .SCORE_W(10)
    ) dut (
        .clk_frame_i   (clk),
        .rst_i         (rst),
        .start_btn_i   (start_btn),
        .pause_btn_i   (pause_btn),
        .hit_i         (hit),
        .miss_i        (miss),
        .play_start_o  (play_start),
        .play_hold_o   (play_hold),
        .freeze_o      (freeze),
        .start_speed_o (start_speed),
        .score_o       (score),
        .lives_o       (lives),
        .level_o       (level),
        .state_o       (state),
        .game_over_o   (game_over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ps;
        logic       hold;
        logic       frz;
        logic [3:0] spd;
        logic [9:0] score;
        logic [2:0] lives;
        logic [1:0] level;
        logic [2:0] st;
        logic       go;
    } outs_t;

    typedef struct {
        string tag;
        outs_t v;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] e_spd;
    logic [9:0] e_score;
    logic [2:0] e_lives;
    logic [1:0] e_level;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic ps,
                            input logic hold, input logic frz);
        exp_t e;
        e.tag = tag;
        e.v   = '{ps, hold, frz, e_spd, e_score, e_lives, e_level, st, (st == ST_GO)};
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t  e;
        outs_t obs;
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed no queued expectation, expected one");
            return;
        end
        e   = sb_q.pop_front();
        obs = '{play_start, play_hold, freeze, start_speed, score, lives, level, state, game_over};
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed st=%0d ps=%b hold=%b frz=%b spd=%b score=%0d lives=%0d lvl=%0d go=%b expected st=%0d ps=%b hold=%b frz=%b spd=%b score=%0d lives=%0d lvl=%0d go=%b",
                   e.tag, obs.st, obs.ps, obs.hold, obs.frz, obs.spd, obs.score, obs.lives, obs.level, obs.go,
                   e.v.st, e.v.ps, e.v.hold, e.v.frz, e.v.spd, e.v.score, e.v.lives, e.v.level, e.v.go);
        end
    endtask

    task automatic do_step(input string tag, input int n, input logic [2:0] st,
                           input logic ps, input logic hold, input logic frz);
        push_exp(tag, st, ps, hold, frz);
        step(n);
        pop_check();
    endtask

    // Called with SERVE already entered; n_wait frames of SERVE remain before the last one.
    task automatic serve_to_play(input string tag, input int n_wait);
        do_step({tag, "_serve"}, n_wait, ST_SERVE, 1'b0, 1'b1, 1'b0);
        do_step({tag, "_launch"}, 1, ST_PLAY, 1'b1, 1'b0, 1'b0);
        do_step({tag, "_play"}, 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_exp();
        e_spd   = 4'b0101;
        e_score = 10'd0;
        e_lives = 3'd3;
        e_level = 2'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; hit = 1'b0; miss = 1'b0;
        reset_exp();
        do_step("reset", 2, ST_IDLE, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        do_step("idle", 3, ST_IDLE, 1'b0, 1'b1, 1'b0);

        // Start edge, serve delay, launch pulse
        start_btn = 1'b1;
        do_step("start", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;
        serve_to_play("m1", 59);

        // Level progression and saturation
        hit = 1'b1;
        e_score = 10'd7;
        do_step("hits7", 7, ST_PLAY, 1'b0, 1'b0, 1'b0);
        e_score = 10'd8; e_level = 2'd1;
        do_step("hits8", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
        hit = 1'b0;
        e_spd = 4'b1001;
        do_step("speed_l1", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
        hit = 1'b1;
        e_score = 10'd40; e_level = 2'd3; e_spd = 4'b1110;
        do_step("hits40", 32, ST_PLAY, 1'b0, 1'b0, 1'b0);
        hit = 1'b0;

        // Hit and miss together: miss wins
        hit = 1'b1; miss = 1'b1;
        e_lives = 3'd2;
        do_step("hit_miss", 1, ST_MISS, 1'b0, 1'b1, 1'b0);
        hit = 1'b0; miss = 1'b0;
        do_step("miss_hold", 89, ST_MISS, 1'b0, 1'b1, 1'b0);
        do_step("miss_to_serve", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        serve_to_play("m2", 59);

        // Pause: hit and miss ignored, second edge resumes
        pause_btn = 1'b1;
        do_step("pause_in", 1, ST_PAUSE, 1'b0, 1'b0, 1'b1);
        pause_btn = 1'b0; miss = 1'b1;
        do_step("pause_miss", 1, ST_PAUSE, 1'b0, 1'b0, 1'b1);
        miss = 1'b0; hit = 1'b1;
        do_step("pause_hit", 1, ST_PAUSE, 1'b0, 1'b0, 1'b1);
        hit = 1'b0; pause_btn = 1'b1;
        do_step("unpause", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
        pause_btn = 1'b0;
        do_step("unpause_idle", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);

        // Pause edge coinciding with a miss is dropped
        pause_btn = 1'b1; miss = 1'b1;
        e_lives = 3'd1;
        do_step("miss_over_pause", 1, ST_MISS, 1'b0, 1'b1, 1'b0);
        pause_btn = 1'b0; miss = 1'b0;
        do_step("miss2_hold", 89, ST_MISS, 1'b0, 1'b1, 1'b0);
        do_step("miss2_to_serve", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        pause_btn = 1'b1;
        do_step("pause_in_serve", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        pause_btn = 1'b0;
        serve_to_play("m3", 58);

        // Last life lost, display frozen, restart from GAME_OVER
        miss = 1'b1;
        e_lives = 3'd0;
        do_step("last_miss", 1, ST_GO, 1'b0, 1'b1, 1'b0);
        miss = 1'b0; hit = 1'b1;
        do_step("go_hit", 1, ST_GO, 1'b0, 1'b1, 1'b0);
        hit = 1'b0;
        start_btn = 1'b1;
        e_score = 10'd0; e_lives = 3'd3; e_level = 2'd0;
        do_step("restart", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;
        e_spd = 4'b0101;
        do_step("restart_spd", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        serve_to_play("m4", 58);

        // Reset mid-PAUSE with start held high through reset
        pause_btn = 1'b1;
        do_step("pause_again", 1, ST_PAUSE, 1'b0, 1'b0, 1'b1);
        pause_btn = 1'b0;
        rst = 1'b1; start_btn = 1'b1;
        reset_exp();
        do_step("rst_pause", 1, ST_IDLE, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        do_step("start_held", 3, ST_IDLE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;
        do_step("start_rel", 1, ST_IDLE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b1;
        do_step("start2", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;
        serve_to_play("m5", 59);

        // Reset mid-MISS
        hit = 1'b1;
        e_score = 10'd1;
        do_step("hit1", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
        hit = 1'b0; miss = 1'b1;
        e_lives = 3'd2;
        do_step("miss_m5", 1, ST_MISS, 1'b0, 1'b1, 1'b0);
        miss = 1'b0;
        do_step("miss_m5_hold", 10, ST_MISS, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        reset_exp();
        do_step("rst_miss", 1, ST_IDLE, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        do_step("idle_after_rst", 1, ST_IDLE, 1'b0, 1'b1, 1'b0);

        // Fresh match: three misses to GAME_OVER
        start_btn = 1'b1;
        do_step("start3", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;
        serve_to_play("f1", 59);
        hit = 1'b1;
        e_score = 10'd1;
        do_step("f_hit", 1, ST_PLAY, 1'b0, 1'b0, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            miss = 1'b1;
            e_lives = e_lives - 3'd1;
            do_step("f_miss", 1, ST_MISS, 1'b0, 1'b1, 1'b0);
            miss = 1'b0;
            do_step("f_miss_hold", 89, ST_MISS, 1'b0, 1'b1, 1'b0);
            do_step("f_reserve", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
            serve_to_play("f_next", 59);
        end
        miss = 1'b1;
        e_lives = 3'd0;
        do_step("f_game_over", 1, ST_GO, 1'b0, 1'b1, 1'b0);
        miss = 1'b0;
        do_step("f_go_hold", 5, ST_GO, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b1;
        e_score = 10'd0; e_lives = 3'd3;
        do_step("f_restart", 1, ST_SERVE, 1'b0, 1'b1, 1'b0);
        start_btn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
